// File: rtl/alu_regfile_byp.sv
// Multi-port register file with same-cycle write bypass and a
// pending-producer scoreboard that tells readers when to stall.
module alu_regfile_byp #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 20,
  parameter int AW    = 5,
  parameter int NRD   = 6,
  parameter int NWR   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_pend,
  output logic                 do_stall,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW-1:0]    raddr_q [NRD];
  logic [AW-1:0]    raddr_d [NRD];
  logic [NRD-1:0]   ren_q, ren_d;
  logic [NRD-1:0]   hit;
  logic [WIDTH-1:0] byp [NRD];

  function automatic logic in_rng(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  // Array writes (higher port wins) and scoreboard; alloc beats clear.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && in_rng(wr_addr[j*AW +: AW])) begin
        mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*WIDTH +: WIDTH];
        pend_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && in_rng(alloc_addr)) begin
      pend_d[alloc_addr] = 1'b1;
    end
  end

  // Read address/enable registers hold while the pipe is stalled.
  always_comb begin
    ren_d = stall ? ren_q : rd_en;
    for (int i = 0; i < NRD; i++) begin
      raddr_d[i] = stall ? raddr_q[i] : rd_addr[i*AW +: AW];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
      pend_q <= '0;
      for (int i = 0; i < NRD; i++) begin
        raddr_q[i] <= '0;
      end
      ren_q <= '0;
    end else begin
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      raddr_q <= raddr_d;
      ren_q   <= ren_d;
    end
  end

  // Read mux: bypass from the highest matching write port, else array.
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NRD; i++) begin
      hit[i] = 1'b0;
      byp[i] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == raddr_q[i]) begin
          hit[i] = 1'b1;
          byp[i] = wr_data[j*WIDTH +: WIDTH];
        end
      end
      if (ren_q[i] && in_rng(raddr_q[i])) begin
        rd_data[i*WIDTH +: WIDTH] = hit[i] ? byp[i]
                                           : mem_q[raddr_q[i]];
        rd_pend[i] = pend_q[raddr_q[i]] & ~hit[i];
      end
    end
  end

  assign do_stall = |rd_pend;

endmodule

// File: tb/tb_alu_regfile_byp.sv
// Bench for alu_regfile_byp: directed scenarios with literal
// expectations plus random traffic against a behavioural model.
module tb_alu_regfile_byp;

  localparam int W = 66;
  localparam int D = 20;
  localparam int A = 5;
  localparam int R = 6;
  localparam int N = 6;

  logic           clk = 0;
  logic           rst = 0;
  logic           stall;
  logic [R-1:0]   rd_en;
  logic [R*A-1:0] rd_addr;
  logic [R*W-1:0] rd_data;
  logic [R-1:0]   rd_pend;
  logic           do_stall;
  logic [N-1:0]   wr_en;
  logic [N*A-1:0] wr_addr;
  logic [N*W-1:0] wr_data;
  logic           alloc_en;
  logic [A-1:0]   alloc_addr;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  logic [W-1:0] m_ram [D];
  bit           m_pend [D];
  int           m_addr [R];
  bit           m_en [R];

  alu_regfile_byp #(
    .WIDTH(W), .DEPTH(D), .AW(A), .NRD(R), .NWR(N)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_pend(rd_pend),
    .do_stall(do_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rdd(int i);
    return rd_data[i*W +: W];
  endfunction

  task automatic model_clear();
    for (int e = 0; e < D; e++) begin
      m_ram[e] = '0;
      m_pend[e] = 0;
    end
    for (int i = 0; i < R; i++) begin
      m_addr[i] = 0;
      m_en[i] = 0;
    end
  endtask

  task automatic model_edge();
    int a;
    for (int j = 0; j < N; j++) begin
      a = int'(wr_addr[j*A +: A]);
      if (wr_en[j] && a < D) begin
        m_ram[a] = wr_data[j*W +: W];
        m_pend[a] = 0;
      end
    end
    if (alloc_en && int'(alloc_addr) < D) m_pend[alloc_addr] = 1;
    if (!stall) begin
      for (int i = 0; i < R; i++) begin
        m_en[i] = rd_en[i];
        m_addr[i] = int'(rd_addr[i*A +: A]);
      end
    end
  endtask

  function automatic int winner(int a);
    int w = -1;
    for (int j = 0; j < N; j++)
      if (wr_en[j] && int'(wr_addr[j*A +: A]) == a) w = j;
    return w;
  endfunction

  function automatic logic [W-1:0] exp_data(int i);
    int w;
    if (!m_en[i] || m_addr[i] >= D) return '0;
    w = winner(m_addr[i]);
    if (w >= 0) return wr_data[w*W +: W];
    return m_ram[m_addr[i]];
  endfunction

  function automatic bit exp_pend(int i);
    if (!m_en[i] || m_addr[i] >= D) return 0;
    if (winner(m_addr[i]) >= 0) return 0;
    return m_pend[m_addr[i]];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) model_edge();
    end
  end

  initial begin
    bit any;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        any = 0;
        for (int i = 0; i < R; i++) begin
          chk($sformatf("model rd_data%0d", i), rdd(i), exp_data(i));
          chk($sformatf("model rd_pend%0d", i),
              W'(rd_pend[i]), W'(exp_pend(i)));
          any |= exp_pend(i);
        end
        chk("model do_stall", W'(do_stall), W'(any));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; rd_en = '0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 0; alloc_addr = '0;
  endtask

  task automatic set_rd(int i, int a);
    rd_en[i] = 1;
    rd_addr[i*A +: A] = A'(a);
  endtask

  task automatic set_wr(int j, int a, logic [W-1:0] d);
    wr_en[j] = 1;
    wr_addr[j*A +: A] = A'(a);
    wr_data[j*W +: W] = d;
  endtask

  task automatic rand_inputs(bit narrow);
    int hi;
    hi = narrow ? 7 : 23;
    stall = ($urandom_range(0, 3) == 0);
    rd_en = R'($urandom);
    for (int i = 0; i < R; i++)
      rd_addr[i*A +: A] = A'($urandom_range(0, hi));
    for (int j = 0; j < N; j++) begin
      wr_en[j] = ($urandom_range(0, 2) == 0);
      wr_addr[j*A +: A] = A'($urandom_range(0, hi));
      wr_data[j*W +: W] = W'({$urandom(), $urandom(), $urandom()});
    end
    alloc_en = ($urandom_range(0, 3) == 0);
    alloc_addr = A'($urandom_range(0, hi));
  endtask

  initial begin
    idle();
    model_clear();
    #1;
    rst = 1;
    model_clear();
    chk_on = 1;
    set_wr(0, 1, 'h5A);
    alloc_en = 1;
    alloc_addr = 1;
    step();
    step();
    chk("reset rd_data0", rdd(0), '0);
    chk("reset do_stall", W'(do_stall), '0);
    rst = 0;
    idle();

    set_wr(0, 3, 'h1234);
    step();
    idle();
    set_rd(0, 3);
    step();
    idle();
    chk("wr-rd data0", rdd(0), 'h1234);
    chk("wr-rd pend0", W'(rd_pend[0]), '0);

    set_rd(1, 7);
    step();
    idle();
    set_wr(2, 7, 'hA);
    set_wr(5, 7, 'hB);
    #1;
    chk("bypass prio data1", rdd(1), 'hB);
    step();
    idle();
    set_rd(1, 7);
    step();
    idle();
    chk("prio array data1", rdd(1), 'hB);

    alloc_en = 1;
    alloc_addr = 9;
    step();
    idle();
    set_rd(0, 9);
    step();
    chk("sb pend0", W'(rd_pend[0]), 'h1);
    chk("sb do_stall", W'(do_stall), 'h1);
    set_wr(1, 9, 'h55);
    #1;
    chk("sb byp pend0", W'(rd_pend[0]), '0);
    chk("sb byp data0", rdd(0), 'h55);
    step();
    wr_en = '0;
    #1;
    chk("sb cleared pend0", W'(rd_pend[0]), '0);
    chk("sb array data0", rdd(0), 'h55);
    idle();

    alloc_en = 1;
    alloc_addr = 4;
    set_wr(0, 4, 'h77);
    step();
    idle();
    set_rd(0, 4);
    step();
    idle();
    chk("collide pend0", W'(rd_pend[0]), 'h1);
    chk("collide data0", rdd(0), 'h77);

    set_wr(0, 2, 'h22);
    set_wr(1, 6, 'h66);
    step();
    idle();
    set_rd(0, 2);
    step();
    stall = 1;
    set_rd(0, 6);
    step();
    chk("stall hold data0", rdd(0), 'h22);
    set_wr(0, 2, 'h99);
    #1;
    chk("stall byp data0", rdd(0), 'h99);
    step();
    wr_en = '0;
    #1;
    chk("stall array data0", rdd(0), 'h99);
    stall = 0;
    step();
    chk("unstall data0", rdd(0), 'h66);
    idle();

    alloc_en = 1;
    alloc_addr = 9;
    step();
    idle();
    set_rd(0, 9);
    set_rd(1, 3);
    step();
    chk("pre-rst do_stall", W'(do_stall), 'h1);
    chk("pre-rst data1", rdd(1), 'h1234);
    #2;
    rst = 1;
    model_clear();
    #1;
    chk("rst data1", rdd(1), '0);
    chk("rst do_stall", W'(do_stall), '0);
    idle();
    set_wr(0, 5, 'hEE);
    step();
    rst = 0;
    idle();
    set_rd(0, 3);
    set_rd(1, 9);
    set_rd(2, 5);
    step();
    idle();
    chk("post-rst data0", rdd(0), '0);
    chk("post-rst pend1", W'(rd_pend[1]), '0);
    chk("post-rst data2", rdd(2), '0);

    for (int c = 0; c < 400; c++) begin
      rand_inputs(c % 3 == 0);
      if (c == 200) begin
        #2;
        rst = 1;
        model_clear();
        step();
        rst = 0;
      end else begin
        step();
      end
    end

    idle();
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
